// File: rtl/muldiv_sequencer_pkg.sv
// Shared MDU types: operation encoding and sequencer state.
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4
    } MulDivOp_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } MdState_t;

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step of the MDU datapath: shift-add multiply (mode=0) or
// restoring shift-subtract divide (mode=1) on a {hi,lo} accumulator.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] acc_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        part = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = part - {1'b0, operand};
        acc_next = acc;
        if (mode) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_next = {sum, acc[WIDTH-1:1]};
            else
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer with valid/ready handshakes producing {HI,LO}.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides always iterate.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  MulDivOp_t        EXE_MulDivOp,
    input  logic [WIDTH-1:0] EXE_ResultA,
    input  logic [WIDTH-1:0] EXE_ResultB,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             EXE_Flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] MDU_HI,
    output logic [WIDTH-1:0] MDU_LO,
    output logic             busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    MdState_t           state;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   operand;
    logic               neg_lo;
    logic               neg_hi;
    logic               bypass;

    logic               op_known;
    logic               op_is_div;
    logic               op_is_signed;
    logic               sign_a;
    logic               sign_b;
    logic               accept;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_known     = EXE_MulDivOp inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    assign op_is_div    = EXE_MulDivOp inside {MDU_DIV, MDU_DIVU};
    assign op_is_signed = EXE_MulDivOp inside {MDU_MULT, MDU_DIV};
    assign sign_a       = op_is_signed & EXE_ResultA[WIDTH-1];
    assign sign_b       = op_is_signed & EXE_ResultB[WIDTH-1];
    assign mag_a        = cond_neg(EXE_ResultA, sign_a);
    assign mag_b        = cond_neg(EXE_ResultB, sign_b);
    assign accept       = in_valid && in_ready && op_known && !EXE_Flush;

`ifdef MDU_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [2*WIDTH-1:0] fast_prod;
    assign prod_s    = $signed({{WIDTH{EXE_ResultA[WIDTH-1]}}, EXE_ResultA})
                     * $signed({{WIDTH{EXE_ResultB[WIDTH-1]}}, EXE_ResultB});
    assign prod_u    = {{WIDTH{1'b0}}, EXE_ResultA} * {{WIDTH{1'b0}}, EXE_ResultB};
    assign fast_prod = op_is_signed ? prod_s : prod_u;
`endif

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc      (acc),
        .operand  (operand),
        .mode     (state == MD_DIV),
        .acc_next (acc_next)
    );

    // Sign fix-up on the final step; bypassed results are already final in acc.
    always_comb begin
        result = acc;
        if (!bypass) begin
            if (state == MD_DIV)
                result = {cond_neg(acc_next[2*WIDTH-1:WIDTH], neg_hi),
                          cond_neg(acc_next[WIDTH-1:0], neg_lo)};
            else
                result = cond_neg_wide(acc_next, neg_lo);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= MD_IDLE;
            counter   <= '0;
            acc       <= '0;
            operand   <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            bypass    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            MDU_HI    <= '0;
            MDU_LO    <= '0;
        end else if (EXE_Flush) begin
            state     <= MD_IDLE;
            counter   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        counter  <= '0;
                        bypass   <= 1'b0;
                        neg_lo   <= sign_a ^ sign_b;
                        neg_hi   <= op_is_div ? sign_a : (sign_a ^ sign_b);
                        if (op_is_div) begin
                            state   <= MD_DIV;
                            operand <= mag_b;
                            // Zero divisor short-circuits to a single completion cycle.
                            if (EXE_ResultB == '0) begin
                                bypass  <= 1'b1;
                                counter <= LAST;
                                acc     <= {EXE_ResultA, {WIDTH{1'b1}}};
                            end else begin
                                acc <= {{WIDTH{1'b0}}, mag_a};
                            end
                        end else begin
                            state   <= MD_MUL;
                            operand <= mag_a;
`ifdef MDU_FAST_MUL_EN
                            bypass  <= 1'b1;
                            counter <= LAST;
                            acc     <= fast_prod;
`else
                            acc     <= {{WIDTH{1'b0}}, mag_b};
`endif
                        end
                    end
                end
                MD_MUL, MD_DIV: begin
                    acc     <= acc_next;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST) begin
                        state     <= MD_DONE;
                        counter   <= '0;
                        out_valid <= 1'b1;
                        MDU_HI    <= result[2*WIDTH-1:WIDTH];
                        MDU_LO    <= result[WIDTH-1:0];
                    end
                end
                MD_DONE: begin
                    if (out_ready) begin
                        state     <= MD_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed cases, flush/reset handling, random ops.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    MulDivOp_t   op;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res = 64'd0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_MulDivOp (op),
        .EXE_ResultA  (a),
        .EXE_ResultB  (b),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .EXE_Flush    (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .MDU_HI       (hi),
        .MDU_LO       (lo),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input MulDivOp_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MDU_MULT:  return 64'(sx * sy);
            MDU_MULTU: return ux * uy;
            MDU_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_latency(input MulDivOp_t o, input logic [31:0] y);
        if ((o == MDU_DIV || o == MDU_DIVU) && y == 32'd0) return 2;
`ifdef MDU_FAST_MUL_EN
        if (o == MDU_MULT || o == MDU_MULTU) return 2;
`endif
        return 33;
    endfunction

    // Called at a negedge; the following posedge is the accept edge.
    task automatic drive_op(input MulDivOp_t o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = MDU_NONE;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    task automatic run_op(input MulDivOp_t o, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [63:0] exp_res;
        int lat;
        exp_q.push_back(model(o, x, y));
        chk("in_ready_idle", in_ready, 1'b1);
        drive_op(o, x, y);
        chk("busy_after_accept", busy, 1'b1);
        wait_valid(lat);
        chk($sformatf("latency_%s", o.name()), lat, exp_latency(o, y));
        exp_res = exp_q.pop_front();
        chk($sformatf("result_%s_%h_%h", o.name(), x, y), {hi, lo}, exp_res);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", {hi, lo}, exp_res);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed_valid", out_valid, 1'b0);
        chk("consumed_in_ready", in_ready, 1'b1);
        last_res = exp_res;
    endtask

    task automatic flush_mid(input logic [31:0] x, input logic [31:0] y, input int iters);
        exp_q.push_back(model(MDU_DIV, x, y));
        drive_op(MDU_DIV, x, y);
        repeat (iters) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(exp_q.pop_front());
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_hilo_kept", {hi, lo}, last_res);
    endtask

    initial begin
        logic [63:0] exp_res;
        logic [31:0] rx, ry;
        MulDivOp_t   ro;
        int          lat;

        resetn = 1'b0;
        op = MDU_NONE;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_const", last_res, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        chk("multu_const", last_res, 64'hFFFF_FFFE_0000_0001);
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_const", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 1);
        chk("divu_const", last_res, 64'h0000_0001_7FFF_FFFC);
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_const", last_res, 64'h0000_0000_8000_0000);
        run_op(MDU_DIVU, 32'd5, 32'd0, 0);
        chk("divu0_const", last_res, 64'h0000_0005_FFFF_FFFF);
        run_op(MDU_DIV, 32'hFFFF_FFF7, 32'd0, 2);
        run_op(MDU_MULTU, 32'd0, 32'h1234_5678, 0);

        // Flush mid-divide, then confirm nothing emerges.
        flush_mid(32'd1000, 32'd7, 10);
        quiet_window("flush_no_valid", 40);

        // Flush then accept a new op on the very next cycle.
        flush_mid(32'd12345, 32'hFFFF_FF00, 5);
        run_op(MDU_MULT, 32'd7, 32'hFFFF_FFF7, 0);

        // Flush coinciding with in_valid must not accept.
        op = MDU_MULT;
        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        op = MDU_NONE;
        chk("flush_accept_in_ready", in_ready, 1'b1);
        chk("flush_accept_busy", busy, 1'b0);
        quiet_window("flush_accept_no_valid", 40);

        // Flush coinciding with out_ready in DONE.
        exp_q.push_back(model(MDU_DIVU, 32'd100, 32'd7));
        drive_op(MDU_DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        chk("latency_done_flush", lat, 33);
        exp_res = exp_q.pop_front();
        chk("result_done_flush", {hi, lo}, exp_res);
        out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        flush = 1'b0;
        chk("done_flush_valid", out_valid, 1'b0);
        chk("done_flush_in_ready", in_ready, 1'b1);
        chk("done_flush_hilo", {hi, lo}, exp_res);
        last_res = exp_res;

        for (int i = 0; i < 6; i++) begin
            ro = MulDivOp_t'($urandom_range(1, 4));
            rx = $urandom;
            ry = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op(ro, rx, ry, $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a multiply.
        exp_q.push_back(model(MDU_MULT, 32'h0001_0003, 32'hFFFF_0005));
        drive_op(MDU_MULT, 32'h0001_0003, 32'hFFFF_0005);
        repeat (8) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        void'(exp_q.pop_front());
        last_res = 64'd0;
        quiet_window("arst_no_valid", 40);
        run_op(MDU_DIV, 32'd77, 32'hFFFF_FFF5, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
